// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types for the LED pattern sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_FILL   = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

endpackage

// File: rtl/led_step_prescaler.sv
// rtl/led_step_prescaler.sv - enabled-cycle tick counter producing one advance every period+1 cycles
module led_step_prescaler #(
  parameter int PER_W = 26
) (
  input  logic             custom_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PER_W-1:0] period,
  output logic             adv
);

  logic [PER_W-1:0] tick_cnt;

  // A clear (mode restart) suppresses the advance that would coincide with it.
  assign adv = en & ~clr & (tick_cnt == period);

  // Count enabled cycles; an exact match with period restarts the count. If
  // period is lowered below the count, the count simply runs on and wraps.
  always_ff @(posedge custom_clk) begin
    if (!rst_n || clr) begin
      tick_cnt <= '0;
    end else if (adv) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - run-time selectable bounce/wrap/fill/blink LED pattern engine
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int PER_W  = 26
) (
  input  logic                      custom_clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  mode_t                     mode,
  input  logic [PER_W-1:0]          period,
  output logic [N_LEDS-1:0]         lights,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      step,
  output logic                      cycle_done
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

  mode_t            mode_q;
  dir_t             dir_q;
  logic [POS_W-1:0] pos_q;
  logic             phase_q;

  logic             restart;
  logic             adv;
  logic [POS_W-1:0] pos_nxt;
  dir_t             dir_nxt;
  logic             phase_nxt;
  logic             wraps;
  logic [31:0]      pos_ext;

  // Any change of the requested mode restarts the pattern, even while frozen.
  assign restart = (mode != mode_q);

  led_step_prescaler #(
    .PER_W (PER_W)
  ) u_prescaler (
    .custom_clk (custom_clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (restart),
    .period     (period),
    .adv        (adv)
  );

  // Next position/direction/phase for one advance, plus whether it lands on the start.
  always_comb begin
    pos_nxt   = pos_q;
    dir_nxt   = dir_q;
    phase_nxt = phase_q;
    wraps     = 1'b0;
    case (mode_q)
      MODE_BOUNCE: begin
        // dir always points at the next move, so each endpoint is shown once.
        if (dir_q == DIR_UP) begin
          if (pos_q >= POS_MAX) begin
            pos_nxt = POS_MAX - 1'b1;
            dir_nxt = DIR_DN;
          end else begin
            pos_nxt = pos_q + 1'b1;
            if (pos_q == POS_MAX - 1'b1) dir_nxt = DIR_DN;
          end
        end else begin
          if (pos_q == '0) begin
            pos_nxt = POS_W'(1);
            dir_nxt = DIR_UP;
          end else begin
            pos_nxt = pos_q - 1'b1;
            if (pos_q == POS_W'(1)) begin
              dir_nxt = DIR_UP;
              wraps   = 1'b1;
            end
          end
        end
      end
      MODE_WRAP, MODE_FILL: begin
        dir_nxt = DIR_UP;
        // Explicit compare keeps non-power-of-two counts inside 0..N-1.
        if (pos_q >= POS_MAX) begin
          pos_nxt = '0;
          wraps   = 1'b1;
        end else begin
          pos_nxt = pos_q + 1'b1;
        end
      end
      default: begin
        pos_nxt   = '0;
        dir_nxt   = DIR_UP;
        phase_nxt = ~phase_q;
        wraps     = phase_q;
      end
    endcase
  end

  // Position state and registered pulses; reset and restart both return to the start.
  always_ff @(posedge custom_clk) begin
    if (!rst_n || restart) begin
      mode_q     <= mode;
      pos_q      <= '0;
      dir_q      <= DIR_UP;
      phase_q    <= 1'b0;
      step       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      step       <= adv;
      cycle_done <= adv & wraps;
      if (adv) begin
        pos_q   <= pos_nxt;
        dir_q   <= dir_nxt;
        phase_q <= phase_nxt;
      end
    end
  end

  assign pos_ext = 32'(pos_q);

  // Decode registered state only, so lights never glitch on input changes.
  always_comb begin
    lights = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      case (mode_q)
        MODE_BOUNCE, MODE_WRAP: lights[i] = (pos_ext == i);
        MODE_FILL:              lights[i] = (i <= pos_ext);
        default:                lights[i] = phase_q;
      endcase
    end
  end

  assign pos = pos_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - randomized and directed checks of two sequencer sizes against a step-count model
module tb_led_pattern_sequencer;

  localparam int PER_W = 26;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [1:0]        md;
  led_seq_pkg::mode_t mode_s;
  logic [PER_W-1:0]  period;

  logic [7:0] lights0;
  logic [2:0] pos0;
  logic       step0, done0;
  logic [4:0] lights1;
  logic [2:0] pos1;
  logic       step1, done1;

  int checks = 0;
  int errors = 0;

  // model: shared prescaler view, per-size step index within one pattern cycle
  int         nv [2] = '{8, 5};
  int         m_cnt;
  logic [1:0] m_mq;
  logic       m_step;
  int         m_k [2];
  logic       m_done [2];

  always #5 clk = ~clk;

  led_pattern_sequencer #(.N_LEDS(8), .PER_W(PER_W)) dut0 (
    .custom_clk (clk), .rst_n (rst_n), .en (en), .mode (mode_s), .period (period),
    .lights (lights0), .pos (pos0), .step (step0), .cycle_done (done0)
  );

  led_pattern_sequencer #(.N_LEDS(5), .PER_W(PER_W)) dut1 (
    .custom_clk (clk), .rst_n (rst_n), .en (en), .mode (mode_s), .period (period),
    .lights (lights1), .pos (pos1), .step (step1), .cycle_done (done1)
  );

  function automatic int cyc_len(int n, logic [1:0] m);
    case (m)
      2'b00:   return 2 * n - 2;
      2'b11:   return 2;
      default: return n;
    endcase
  endfunction

  function automatic int epos(int n, logic [1:0] m, int k);
    case (m)
      2'b00:   return (k < n) ? k : 2 * n - 2 - k;
      2'b11:   return 0;
      default: return k;
    endcase
  endfunction

  function automatic logic [63:0] elights(int n, logic [1:0] m, int k);
    int p;
    p = epos(n, m, k);
    case (m)
      2'b00, 2'b01: return 64'd1 << p;
      2'b10:        return (64'd1 << (p + 1)) - 64'd1;
      default:      return (k == 1) ? ((64'd1 << n) - 64'd1) : 64'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    if (!rst_n || md != m_mq) begin
      m_cnt = 0;
      m_mq = md;
      m_step = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_k[d] = 0;
        m_done[d] = 1'b0;
      end
    end else if (en && m_cnt == int'(period)) begin
      m_cnt = 0;
      m_step = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_k[d] = (m_k[d] + 1) % cyc_len(nv[d], m_mq);
        m_done[d] = (m_k[d] == 0);
      end
    end else begin
      if (en) m_cnt++;
      m_step = 1'b0;
      for (int d = 0; d < 2; d++) m_done[d] = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("n8_lights", 64'(lights0), elights(8, m_mq, m_k[0]));
    chk("n8_pos",    64'(pos0),    64'(epos(8, m_mq, m_k[0])));
    chk("n8_step",   64'(step0),   64'(m_step));
    chk("n8_done",   64'(done0),   64'(m_done[0]));
    chk("n5_lights", 64'(lights1), elights(5, m_mq, m_k[1]));
    chk("n5_pos",    64'(pos1),    64'(epos(5, m_mq, m_k[1])));
    chk("n5_step",   64'(step1),   64'(m_step));
    chk("n5_done",   64'(done1),   64'(m_done[1]));
  endtask

  task automatic cyc(input logic r, input logic e, input logic [1:0] m, input int p);
    rst_n  = r;
    en     = e;
    md     = m;
    mode_s = led_seq_pkg::mode_t'(m);
    period = PER_W'(p);
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic run(input int n, input logic e, input logic [1:0] m, input int p);
    for (int i = 0; i < n; i++) cyc(1'b1, e, m, p);
  endtask

  initial begin
    int b;
    int cur_p;
    logic [1:0] cur_m;
    m_cnt = 0;
    m_mq = 2'b00;
    m_step = 1'b0;
    m_k = '{0, 0};
    m_done = '{1'b0, 1'b0};

    // reset into BOUNCE, period 0
    cyc(1'b0, 1'b1, 2'b00, 0);
    cyc(1'b0, 1'b1, 2'b00, 0);
    chk("reset_lights", 64'(lights0), 64'h01);
    chk("reset_pos",    64'(pos0),    64'd0);
    chk("reset_step",   64'(step0),   64'd0);
    chk("reset_done",   64'(done0),   64'd0);

    // BOUNCE every cycle, two full sweeps
    run(30, 1'b1, 2'b00, 0);
    // WRAP with period 3
    run(40, 1'b1, 2'b01, 3);
    // FILL every cycle
    run(20, 1'b1, 2'b10, 0);
    // BLINK with period 1
    run(20, 1'b1, 2'b11, 1);

    // BOUNCE to pos 5 heading down, freeze, resume
    b = 0;
    cyc(1'b1, 1'b1, 2'b00, 0);
    while (m_k[0] != 9 && b < 100) begin
      cyc(1'b1, 1'b1, 2'b00, 0);
      b++;
    end
    chk("bounce_at5", 64'(pos0), 64'd5);
    run(10, 1'b0, 2'b00, 0);
    chk("frozen_pos", 64'(pos0), 64'd5);
    cyc(1'b1, 1'b1, 2'b00, 0);
    chk("resume_pos", 64'(pos0), 64'd4);
    cyc(1'b1, 1'b1, 2'b00, 0);
    chk("bounce_at3", 64'(pos0), 64'd3);
    // mode change coincident with an advance: restart wins
    cyc(1'b1, 1'b1, 2'b01, 0);
    chk("restart_lights", 64'(lights0), 64'h01);
    chk("restart_done",   64'(done0),   64'd0);
    chk("restart_step",   64'(step0),   64'd0);
    run(12, 1'b1, 2'b01, 0);

    // reset in the middle of FILL at pos 6
    b = 0;
    cyc(1'b1, 1'b1, 2'b10, 0);
    while (m_k[0] != 6 && b < 100) begin
      cyc(1'b1, 1'b1, 2'b10, 0);
      b++;
    end
    chk("fill_at6", 64'(lights0), 64'h7F);
    cyc(1'b0, 1'b1, 2'b10, 0);
    chk("rst_lights", 64'(lights0), 64'h01);
    chk("rst_pos",    64'(pos0),    64'd0);
    chk("rst_step",   64'(step0),   64'd0);

    // randomized run: gaps in en, occasional mode/period change and reset
    cur_m = 2'b00;
    cur_p = 0;
    for (int i = 0; i < 600; i++) begin
      logic [1:0] nm;
      logic r;
      logic e;
      e = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 29) == 0) begin
        nm = 2'($urandom_range(0, 3));
        if (nm != cur_m) begin
          cur_m = nm;
          cur_p = $urandom_range(0, 3);
        end
      end
      cyc(r, e, cur_m, cur_p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
